hazard_forward_unit: RTL and testbench

Parametrised hazard-detection and operand-forwarding controller for the in-order pipeline. It replaces the per-core ad-hoc stall flops: a single registered scoreboard tracks destination registers in flight past decode. From it the block produces the decode-stage operands with forwarding, load-use stalls, flush bubbles and a stall counter. It sits beside the decode stage and drives the fetch→decode and decode→execute flop enables.

---
 rtl/hazard_forward_unit.sv | 136 +++++++++++++
 tb/tb_hazard_forward_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Scoreboard of destination registers in flight past decode. Produces the
// forwarded decode operands, load-use stalls, flush bubbles and a saturating
// stall-cycle counter. Tracker index 0 is EXECUTE; higher indices are older.
module hazard_forward_unit #(
  parameter int XLEN           = 32,
  parameter int REGISTER_SIZE  = 5,
  parameter int NUM_SRC        = 2,
  parameter int TRACK_DEPTH    = 3,
  parameter int LOAD_READY_IDX = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            dec_valid,
  input  logic [NUM_SRC*REGISTER_SIZE-1:0]                dec_rs_addr,
  input  logic [NUM_SRC-1:0]                              dec_rs_used,
  input  logic [REGISTER_SIZE-1:0]                        dec_rd_addr,
  input  logic                                            dec_rd_write,
  input  logic                                            dec_is_load,
  input  logic [NUM_SRC*XLEN-1:0]                         rf_read_data,
  input  logic [TRACK_DEPTH*XLEN-1:0]                     stage_data,
  input  logic                                            redirect,
  input  logic                                            hold,
  output logic [NUM_SRC*XLEN-1:0]                         operand_out,
  output logic [NUM_SRC*$clog2(TRACK_DEPTH+1)-1:0]        fwd_sel,
  output logic                                            f_to_d_enable,
  output logic                                            d_to_e_enable,
  output logic                                            bubble,
  output logic [CNT_WIDTH-1:0]                            stall_count
);

  localparam int SEL_W = $clog2(TRACK_DEPTH + 1);

  logic [TRACK_DEPTH-1:0]                    trk_valid_q, trk_valid_d;
  logic [TRACK_DEPTH-1:0][REGISTER_SIZE-1:0] trk_rd_q, trk_rd_d;
  logic [TRACK_DEPTH-1:0]                    trk_load_q, trk_load_d;
  logic [CNT_WIDTH-1:0]                      stall_count_q, stall_count_d;

  logic [NUM_SRC-1:0] src_hit;
  logic [NUM_SRC-1:0] src_hazard;
  logic               load_use;
  logic               shift_en;
  logic               ins_valid;
  logic               cnt_inc;

  // Per-source search for the youngest writer; select forwarded data or flag a load-use hazard.
  always_comb begin
    src_hit     = '0;
    src_hazard  = '0;
    operand_out = rf_read_data;
    fwd_sel     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 0; k < TRACK_DEPTH; k++) begin
        if (!src_hit[s] && dec_rs_used[s]
            && (|dec_rs_addr[s*REGISTER_SIZE +: REGISTER_SIZE])
            && trk_valid_q[k] && (|trk_rd_q[k])
            && (trk_rd_q[k] == dec_rs_addr[s*REGISTER_SIZE +: REGISTER_SIZE])) begin
          src_hit[s] = 1'b1;
          if (trk_load_q[k] && (k < LOAD_READY_IDX)) begin
            // Result not yet produced; operand stays on the register file path.
            src_hazard[s] = 1'b1;
          end else begin
            operand_out[s*XLEN +: XLEN] = stage_data[k*XLEN +: XLEN];
            fwd_sel[s*SEL_W +: SEL_W]   = SEL_W'(k + 1);
          end
        end
      end
    end
    load_use = dec_valid && (|src_hazard);
  end

  // Pipeline control priority: hold, then redirect, then load-use, then normal flow.
  always_comb begin
    f_to_d_enable = 1'b1;
    d_to_e_enable = 1'b1;
    bubble        = 1'b0;
    shift_en      = 1'b1;
    ins_valid     = dec_valid && dec_rd_write;
    cnt_inc       = 1'b0;
    if (hold) begin
      f_to_d_enable = 1'b0;
      d_to_e_enable = 1'b0;
      shift_en      = 1'b0;
      ins_valid     = 1'b0;
    end else if (redirect) begin
      bubble    = 1'b1;
      ins_valid = 1'b0;
    end else if (load_use) begin
      f_to_d_enable = 1'b0;
      d_to_e_enable = 1'b0;
      bubble        = 1'b1;
      ins_valid     = 1'b0;
      cnt_inc       = 1'b1;
    end
  end

  // Next tracker contents and saturating stall counter.
  always_comb begin
    trk_valid_d = trk_valid_q;
    trk_rd_d    = trk_rd_q;
    trk_load_d  = trk_load_q;
    if (shift_en) begin
      for (int k = TRACK_DEPTH - 1; k > 0; k--) begin
        trk_valid_d[k] = trk_valid_q[k-1];
        trk_rd_d[k]    = trk_rd_q[k-1];
        trk_load_d[k]  = trk_load_q[k-1];
      end
      trk_valid_d[0] = ins_valid;
      trk_rd_d[0]    = dec_rd_addr;
      trk_load_d[0]  = dec_is_load;
    end
    stall_count_d = stall_count_q;
    if (cnt_inc && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      trk_valid_q   <= '0;
      trk_rd_q      <= '0;
      trk_load_q    <= '0;
      stall_count_q <= '0;
    end else begin
      trk_valid_q   <= trk_valid_d;
      trk_rd_q      <= trk_rd_d;
      trk_load_q    <= trk_load_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit (default widths, 2-bit stall counter).
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [9:0]  dec_rs_addr;
  logic [1:0]  dec_rs_used;
  logic [4:0]  dec_rd_addr;
  logic        dec_rd_write;
  logic        dec_is_load;
  logic [63:0] rf_read_data;
  logic [95:0] stage_data;
  logic        redirect;
  logic        hold;
  logic [63:0] operand_out;
  logic [3:0]  fwd_sel;
  logic        f_to_d_enable;
  logic        d_to_e_enable;
  logic        bubble;
  logic [1:0]  stall_count;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0000;

  hazard_forward_unit #(
    .XLEN(32), .REGISTER_SIZE(5), .NUM_SRC(2), .TRACK_DEPTH(3),
    .LOAD_READY_IDX(1), .CNT_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs_addr(dec_rs_addr),
    .dec_rs_used(dec_rs_used), .dec_rd_addr(dec_rd_addr), .dec_rd_write(dec_rd_write),
    .dec_is_load(dec_is_load), .rf_read_data(rf_read_data), .stage_data(stage_data),
    .redirect(redirect), .hold(hold), .operand_out(operand_out), .fwd_sel(fwd_sel),
    .f_to_d_enable(f_to_d_enable), .d_to_e_enable(d_to_e_enable), .bubble(bubble),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic wr, input logic ld);
    dec_valid    = v;
    dec_rs_addr  = {rs1, rs0};
    dec_rs_used  = used;
    dec_rd_addr  = rd;
    dec_rd_write = wr;
    dec_is_load  = ld;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl = {f_to_d_enable, d_to_e_enable, bubble}
  task automatic chk_ctl(input string tag, input logic [2:0] exp);
    chk(tag, {61'd0, f_to_d_enable, d_to_e_enable, bubble}, {61'd0, exp});
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; hold = 1'b0;
    rf_read_data = {RF1, RF0};
    stage_data   = '0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd5, 1'b1, 1'b0);
    chk_ctl("reset_ctl", 3'b110);
    chk("reset_fwd_sel", {60'd0, fwd_sel}, 64'd0);
    chk("reset_operands", operand_out, {RF1, RF0});
    chk("reset_count", {62'd0, stall_count}, 64'd0);
    tick();  // add x5 enters EXECUTE

    // Back-to-back ALU dependency: sub rs1=x5
    stage_data = {32'h0, 32'h0, 32'h0000_0010};
    drive(1'b1, 5'd5, 5'd6, 2'b11, 5'd8, 1'b1, 1'b0);
    chk("alu_fwd_sel", {60'd0, fwd_sel}, 64'h1);
    chk("alu_operands", operand_out, {RF1, 32'h0000_0010});
    chk_ctl("alu_ctl", 3'b110);
    tick();

    // Load-use: lw x7 then add rs2=x7
    drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd7, 1'b1, 1'b1);
    tick();
    stage_data = {32'h0, 32'hDEAD_BEEF, 32'h0};
    drive(1'b1, 5'd2, 5'd7, 2'b11, 5'd9, 1'b1, 1'b0);
    chk_ctl("lu_stall_ctl", 3'b001);
    chk("lu_stall_count0", {62'd0, stall_count}, 64'd0);
    tick();
    chk_ctl("lu_resume_ctl", 3'b110);
    chk("lu_fwd_sel", {60'd0, fwd_sel}, 64'h8);
    chk("lu_operands", operand_out, {32'hDEAD_BEEF, RF0});
    chk("lu_count1", {62'd0, stall_count}, 64'd1);
    tick();

    // Youngest wins: x3 (oldest), x4, x3 (youngest), then reader
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0); tick();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0); tick();
    stage_data = {32'h0000_0002, 32'h0000_0099, 32'h0000_0001};
    drive(1'b1, 5'd3, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0);
    chk("young_fwd_sel", {60'd0, fwd_sel}, 64'h9);
    chk("young_operands", operand_out, {32'h0000_0099, 32'h0000_0001});
    tick();

    // x0 and unused: lw x0 in flight, rs1=x0 used, rs2=x3 not used
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd0, 5'd3, 2'b01, 5'd0, 1'b0, 1'b0);
    chk("x0_fwd_sel", {60'd0, fwd_sel}, 64'd0);
    chk("x0_operands", operand_out, {RF1, RF0});
    chk_ctl("x0_ctl", 3'b110);
    tick();

    // Redirect during a pending load-use
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 1'b1); tick();
    redirect = 1'b1;
    drive(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    chk_ctl("redir_ctl", 3'b111);
    tick();
    redirect = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    chk("redir_count", {62'd0, stall_count}, 64'd1);

    // Hold for 3 cycles with a load-use pending
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 1'b1); tick();
    hold = 1'b1;
    drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
    chk_ctl("hold_ctl", 3'b000);
    tick(); tick(); tick();
    chk_ctl("hold_ctl_after3", 3'b000);
    hold = 1'b0;
    drive(1'b1, 5'd11, 5'd0, 2'b01, 5'd12, 1'b1, 1'b0);
    chk_ctl("hold_resume_stall", 3'b001);
    chk("hold_count", {62'd0, stall_count}, 64'd1);
    tick();
    chk("hold_stall_count2", {62'd0, stall_count}, 64'd2);
    chk("hold_fwd_sel", {60'd0, fwd_sel}, 64'h2);
    tick();

    // Reset mid-stall
    drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd13, 1'b1, 1'b1); tick();
    drive(1'b1, 5'd13, 5'd13, 2'b11, 5'd0, 1'b0, 1'b0);
    chk_ctl("rst_pre_stall", 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 5'd13, 5'd13, 2'b11, 5'd0, 1'b0, 1'b0);
    chk_ctl("rst_post_ctl", 3'b110);
    chk("rst_post_fwd_sel", {60'd0, fwd_sel}, 64'd0);
    chk("rst_post_operands", operand_out, {RF1, RF0});
    chk("rst_post_count", {62'd0, stall_count}, 64'd0);

    // Saturation: five load-use stalls on a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd14, 1'b1, 1'b1); tick();
      drive(1'b1, 5'd14, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
      chk_ctl("sat_stall_ctl", 3'b001);
      tick();
      chk("sat_count", {62'd0, stall_count}, (i >= 3) ? 64'd3 : 64'(i));
      tick();
    end
    chk("sat_final", {62'd0, stall_count}, 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
